// File: rtl/load_store_unit.sv
// load_store_unit: initiator side of the data-memory port for RV32I loads/stores (mask, lane replication, extension, timeout).
// Optional feature macro MISALIGN_TRAP_EN: misaligned H/W accesses end with err instead of being forced to natural alignment.
module load_store_unit #(
  parameter int ADDR_W      = 8,
  parameter int TIMEOUT_CYC = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ls_req,
  input  logic              ls_store,
  input  logic [2:0]        ls_funct3,
  input  logic [31:0]       ls_addr,
  input  logic [31:0]       ls_wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [31:0]       rdata,
  output logic              mem_request,
  output logic              mem_we_re,
  output logic              mem_load,
  output logic [3:0]        mem_mask,
  output logic [ADDR_W-1:0] mem_address,
  output logic [31:0]       mem_data_in,
  input  logic              mem_valid,
  input  logic [31:0]       mem_data_out
);

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, WAIT = 2'd2, DONE = 2'd3} state_t;

  localparam int               CNT_W    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  state_t           state_r;
  logic [CNT_W-1:0] cnt_r;
  logic             store_r;
  logic [2:0]       funct3_r;
  logic [1:0]       off_r;
  logic             trap_r;
  logic [1:0]       off_s;
  logic             trap_s;
  logic             unused_s;

  function automatic logic [1:0] align_off(input logic [2:0] f3, input logic [1:0] o);
    case (f3[1:0])
      2'b00:   align_off = o;
      2'b01:   align_off = {o[1], 1'b0};
      default: align_off = 2'b00;
    endcase
  endfunction

  function automatic logic [3:0] gen_mask(input logic [2:0] f3, input logic [1:0] o);
    case (f3[1:0])
      2'b00:   gen_mask = 4'b0001 << o;
      2'b01:   gen_mask = 4'b0011 << {o[1], 1'b0};
      default: gen_mask = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] gen_wdata(input logic [2:0] f3, input logic [31:0] d);
    case (f3[1:0])
      2'b00:   gen_wdata = {4{d[7:0]}};
      2'b01:   gen_wdata = {2{d[15:0]}};
      default: gen_wdata = d;
    endcase
  endfunction

  function automatic logic [31:0] fmt_load(input logic [2:0] f3, input logic [1:0] o,
                                           input logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{o, 3'b000} +: 8];
    h = o[1] ? w[31:16] : w[15:0];
    case (f3)
      3'b000:  fmt_load = {{24{b[7]}}, b};
      3'b001:  fmt_load = {{16{h[15]}}, h};
      3'b100:  fmt_load = {24'd0, b};
      3'b101:  fmt_load = {16'd0, h};
      default: fmt_load = w;
    endcase
  endfunction

  // Natural-alignment offset and misalignment detect for the incoming command.
  always_comb begin
    off_s = align_off(ls_funct3, ls_addr[1:0]);
`ifdef MISALIGN_TRAP_EN
    trap_s = (off_s != ls_addr[1:0]);
`else
    trap_s = 1'b0;
`endif
  end

  assign unused_s = ^{ls_addr[31:ADDR_W+2]};

  // Command FSM; every output is a register updated here.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      cnt_r       <= '0;
      store_r     <= 1'b0;
      funct3_r    <= 3'b000;
      off_r       <= 2'b00;
      trap_r      <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
      rdata       <= 32'h0000_0000;
      mem_request <= 1'b0;
      mem_we_re   <= 1'b0;
      mem_load    <= 1'b0;
      mem_mask    <= 4'b0000;
      mem_address <= '0;
      mem_data_in <= 32'h0000_0000;
    end else begin
      mem_request <= 1'b0;
      mem_we_re   <= 1'b0;
      mem_load    <= 1'b0;
      done        <= 1'b0;
      case (state_r)
        IDLE: begin
          if (ls_req) begin
            store_r  <= ls_store;
            funct3_r <= ls_funct3;
            off_r    <= off_s;
            trap_r   <= trap_s;
            busy     <= 1'b1;
            cnt_r    <= '0;
            if (trap_s) begin
              // Misaligned access never reaches memory; WAIT spends one cycle before the error completion.
              state_r <= WAIT;
            end else begin
              mem_request <= 1'b1;
              mem_we_re   <= ls_store;
              mem_load    <= ~ls_store;
              mem_mask    <= gen_mask(ls_funct3, off_s);
              mem_address <= ls_addr[ADDR_W+1:2];
              mem_data_in <= gen_wdata(ls_funct3, ls_wdata);
              state_r     <= REQ;
            end
          end else begin
            state_r <= IDLE;
          end
        end
        REQ: begin
          cnt_r <= '0;
          if (store_r) begin
            err     <= 1'b0;
            done    <= 1'b1;
            busy    <= 1'b0;
            state_r <= DONE;
          end else begin
            state_r <= WAIT;
          end
        end
        WAIT: begin
          cnt_r <= cnt_r + CNT_W'(1);
          if (trap_r) begin
            err     <= 1'b1;
            rdata   <= 32'h0000_0000;
            done    <= 1'b1;
            busy    <= 1'b0;
            trap_r  <= 1'b0;
            state_r <= DONE;
          end else if (mem_valid) begin
            err     <= 1'b0;
            rdata   <= fmt_load(funct3_r, off_r, mem_data_out);
            done    <= 1'b1;
            busy    <= 1'b0;
            state_r <= DONE;
          end else if (cnt_r == CNT_LAST) begin
            err     <= 1'b1;
            rdata   <= 32'h0000_0000;
            done    <= 1'b1;
            busy    <= 1'b0;
            state_r <= DONE;
          end else begin
            state_r <= WAIT;
          end
        end
        DONE: begin
          state_r <= IDLE;
        end
        default: begin
          state_r <= IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed cases plus random loads/stores against a byte-level reference memory.
module tb_load_store_unit;
  localparam int ADDR_W = 8;
  localparam int TO     = 15;

  logic        clk = 1'b0;
  logic        rst;
  logic        ls_req, ls_store;
  logic [2:0]  ls_funct3;
  logic [31:0] ls_addr, ls_wdata;
  logic        busy, done, err;
  logic [31:0] rdata;
  logic        mem_request, mem_we_re, mem_load;
  logic [3:0]  mem_mask;
  logic [ADDR_W-1:0] mem_address;
  logic [31:0] mem_data_in;
  logic        mem_valid;
  logic [31:0] mem_data_out;

  always #5 clk = ~clk;

  load_store_unit #(.ADDR_W(ADDR_W), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst(rst), .ls_req(ls_req), .ls_store(ls_store), .ls_funct3(ls_funct3),
    .ls_addr(ls_addr), .ls_wdata(ls_wdata), .busy(busy), .done(done), .err(err),
    .rdata(rdata), .mem_request(mem_request), .mem_we_re(mem_we_re), .mem_load(mem_load),
    .mem_mask(mem_mask), .mem_address(mem_address), .mem_data_in(mem_data_in),
    .mem_valid(mem_valid), .mem_data_out(mem_data_out)
  );

  int tests = 0;
  int fails = 0;
  logic [31:0] mem   [0:255];
  logic [7:0]  ref_b [0:1023];
  logic        mem_dead = 1'b0;
  int          req_count = 0;

  logic        s_busy, s_done, s_err, s_req, s_we, s_ld;
  logic [31:0] s_rdata, s_din;
  logic [3:0]  s_mask;
  logic [7:0]  s_addr;
  logic        r_we, r_ld;
  logic [3:0]  r_mask;
  logic [7:0]  r_addr;
  logic [31:0] r_din;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: sample outputs mid-cycle, then act as a memory with a registered valid.
  task automatic step();
    @(negedge clk);
    s_busy = busy; s_done = done; s_err = err; s_rdata = rdata;
    s_req = mem_request; s_we = mem_we_re; s_ld = mem_load;
    s_mask = mem_mask; s_addr = mem_address; s_din = mem_data_in;
    if (s_req) begin
      req_count++;
      r_we = s_we; r_ld = s_ld; r_mask = s_mask; r_addr = s_addr; r_din = s_din;
    end
    @(posedge clk);
    #1;
    if (s_req && s_we)
      for (int j = 0; j < 4; j++)
        if (s_mask[j]) mem[s_addr][8*j +: 8] = s_din[8*j +: 8];
    mem_valid    = s_req && s_ld && !mem_dead;
    mem_data_out = mem_valid ? mem[s_addr] : $urandom();
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ctrl"}, {26'd0, s_busy, s_done, s_err, s_req, s_we, s_ld}, 32'd0);
    chk({tag, "_mask"}, {28'd0, s_mask}, 32'd0);
    chk({tag, "_addr"}, {24'd0, s_addr}, 32'd0);
    chk({tag, "_din"}, s_din, 32'd0);
    chk({tag, "_rdata"}, s_rdata, 32'd0);
  endtask

  task automatic run_op(input string tag, input logic st, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wd, input int extra_at);
    int size, off, base, lat, lat_exp, reqs0, reqs_exp;
    logic trap, unsgn, busy_ok;
    logic [3:0] m_exp;
    logic [31:0] d_exp, r_exp;
    longint v;
    size  = (f3 == 3'd0 || f3 == 3'd4) ? 1 : ((f3 == 3'd1 || f3 == 3'd5) ? 2 : 4);
    unsgn = (f3 == 3'd4 || f3 == 3'd5);
    off   = int'(addr % 32'd4);
    base  = int'(addr % 32'd1024) - off;
`ifdef MISALIGN_TRAP_EN
    trap = (off % size) != 0;
`else
    trap = 1'b0;
`endif
    off   = off - (off % size);
    m_exp = 4'(((1 << size) - 1) << off);
    for (int j = 0; j < 4; j++) d_exp[8*j +: 8] = wd[8*(j % size) +: 8];
    r_exp = 32'd0;
    if (!trap && st)
      for (int k = 0; k < size; k++) ref_b[base + off + k] = wd[8*k +: 8];
    if (!trap && !st && !mem_dead) begin
      v = 0;
      for (int k = 0; k < size; k++) v = v | (longint'(ref_b[base + off + k]) << (8 * k));
      if (!unsgn && size < 4 && v >= (longint'(1) << (8 * size - 1)))
        v = v - (longint'(1) << (8 * size));
      r_exp = v[31:0];
    end
    lat_exp  = (trap || st) ? 2 : (mem_dead ? 2 + TO : 3);
    reqs_exp = trap ? 0 : 1;

    reqs0 = req_count;
    ls_req = 1'b1; ls_store = st; ls_funct3 = f3; ls_addr = addr; ls_wdata = wd;
    step();
    ls_req = 1'b0; ls_store = 1'($urandom); ls_funct3 = 3'($urandom);
    ls_addr = $urandom; ls_wdata = $urandom;
    lat = -1;
    busy_ok = 1'b1;
    for (int i = 1; i <= 60; i++) begin
      if (i == extra_at) ls_req = 1'b1;
      step();
      ls_req = 1'b0;
      if (s_done) begin
        lat = i;
        break;
      end
      if (!s_busy) busy_ok = 1'b0;
    end
    chk({tag, "_lat"}, 32'(lat), 32'(lat_exp));
    chk({tag, "_busy"}, {31'd0, busy_ok & ~s_busy}, 32'd1);
    chk({tag, "_err"}, {31'd0, s_err}, {31'd0, trap || (!st && mem_dead)});
    if (trap || !st) chk({tag, "_rdata"}, s_rdata, r_exp);
    chk({tag, "_nreq"}, 32'(req_count - reqs0), 32'(reqs_exp));
    if (!trap) begin
      chk({tag, "_mask"}, {28'd0, r_mask}, {28'd0, m_exp});
      chk({tag, "_addr"}, {24'd0, r_addr}, {24'd0, addr[9:2]});
      chk({tag, "_dir"}, {30'd0, r_we, r_ld}, {30'd0, st, ~st});
      if (st) chk({tag, "_din"}, r_din, d_exp);
    end
    reqs0 = req_count;
    for (int i = 0; i < 2; i++) begin
      step();
      chk({tag, "_idle"}, {30'd0, s_busy, s_done}, 32'd0);
    end
    chk({tag, "_noqueue"}, 32'(req_count - reqs0), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] x;
    rst = 1'b1; ls_req = 1'b0; ls_store = 1'b0; ls_funct3 = 3'd0; ls_addr = 32'd0; ls_wdata = 32'd0;
    mem_valid = 1'b0; mem_data_out = 32'd0;
    for (int w = 0; w < 256; w++) begin
      x = $urandom();
      mem[w] = x;
      for (int k = 0; k < 4; k++) ref_b[4*w + k] = x[8*k +: 8];
    end
    step();
    chk_zero("reset");
    step();
    rst = 1'b0;

    run_op("sw", 1'b1, 3'b010, 32'h0000_0010, 32'hDEAD_BEEF, 0);
    chk("sw_mask_c", {28'd0, r_mask}, 32'h0000_000F);
    chk("sw_din_c", r_din, 32'hDEAD_BEEF);
    run_op("sb", 1'b1, 3'b000, 32'h0000_0013, 32'h0000_00A5, 0);
    chk("sb_mask_c", {28'd0, r_mask}, 32'h0000_0008);
    chk("sb_din_c", r_din, 32'hA5A5_A5A5);
    chk("sb_addr_c", {24'd0, r_addr}, 32'h0000_0004);

    run_op("sw20", 1'b1, 3'b010, 32'h0000_0020, 32'h80F0_7F01, 0);
    run_op("lb", 1'b0, 3'b000, 32'h0000_0023, 32'd0, 0);
    chk("lb_c", s_rdata, 32'hFFFF_FF80);
    run_op("lbu", 1'b0, 3'b100, 32'h0000_0023, 32'd0, 0);
    chk("lbu_c", s_rdata, 32'h0000_0080);
    run_op("lh", 1'b0, 3'b001, 32'h0000_0022, 32'd0, 0);
    chk("lh_c", s_rdata, 32'hFFFF_80F0);
    run_op("lhu", 1'b0, 3'b101, 32'h0000_0020, 32'd0, 0);
    chk("lhu_c", s_rdata, 32'h0000_7F01);

    mem_dead = 1'b1;
    run_op("lw_timeout", 1'b0, 3'b010, 32'h0000_0040, 32'd0, 5);
    mem_dead = 1'b0;

    // Reset while the load is parked in WAIT.
    mem_dead = 1'b1;
    ls_req = 1'b1; ls_store = 1'b0; ls_funct3 = 3'b010; ls_addr = 32'h0000_0080;
    step();
    ls_req = 1'b0;
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    chk_zero("midrst");
    step();
    chk("midrst_nodone", {31'd0, s_done}, 32'd0);
    mem_dead = 1'b0;
    run_op("lw_after_rst", 1'b0, 3'b010, 32'h0000_0020, 32'd0, 0);
    chk("lw_after_rst_c", s_rdata, 32'h80F0_7F01);

    run_op("lw_mis", 1'b0, 3'b010, 32'h0000_0022, 32'd0, 0);
`ifdef MISALIGN_TRAP_EN
    chk("lw_mis_c", {31'd0, s_err}, 32'd1);
`else
    chk("lw_mis_c", s_rdata, 32'h80F0_7F01);
    chk("lw_mis_addr_c", {24'd0, r_addr}, 32'h0000_0008);
`endif

    for (int n = 0; n < 40; n++)
      run_op("rnd", 1'($urandom), 3'($urandom_range(0, 7)),
             ($urandom & 32'hFFFF_FC00) | 32'($urandom_range(0, 63)), $urandom, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Initiator side of the data-memory port: takes load/store commands from the core's execute stage and issues memory requests with request, we_re, load, mask, word address and store data.
- Waits for the memory's registered valid on loads, then extracts, aligns and sign- or zero-extends the returned word.
- Sits between the execute/writeback stages and the data memory top; drives its ports directly.

Parameters:
- ADDR_W, 8, width of the memory word address (mem_address = addr[ADDR_W+1:2])
- TIMEOUT_CYC, 15, cycles spent in WAIT without mem_valid before aborting with err

Ports:
- clk  input  1  clock
- rst  input  1  reset, synchronous, active-high
- ls_req  input  1  command strobe, sampled only when busy=0
- ls_store  input  1  1=store, 0=load
- ls_funct3  input  3  RV32I size code: 000 B, 001 H, 010 W, 100 BU, 101 HU
- ls_addr  input  32  byte address
- ls_wdata  input  32  store data (low-aligned)
- busy  output  1  command in flight
- done  output  1  one-cycle completion pulse
- err  output  1  valid with done; timeout (or misalignment, see feature)
- rdata  output  32  formatted load result, valid with done
- mem_request  output  1  memory request strobe
- mem_we_re  output  1  1=write, 0=read
- mem_load  output  1  load indication to memory (drives its valid)
- mem_mask  output  4  byte enables
- mem_address  output  ADDR_W  word address
- mem_data_in  output  32  lane-replicated store data
- mem_valid  input  1  load data valid from memory
- mem_data_out  input  32  memory read word

Behaviour:
- Reset values: all outputs 0, state IDLE, timeout counter 0.
- Reset mid-operation: return to IDLE on the next edge. No done pulse. Outputs are zeroed.
- All outputs are registered.
- FSM states: IDLE, REQ, WAIT, DONE.
- IDLE: when ls_req=1, latch command fields, set busy=1 and go to REQ. If ls_req=0, stay in IDLE.
- ls_req while busy=1 is ignored (not queued).
- REQ (exactly one cycle):
  - mem_request=1, mem_we_re=ls_store, mem_load=~ls_store; mask, address and data are valid.
  - Store: go to DONE.
  - Load: go to WAIT.
- In all states other than REQ, mem_request, mem_load and mem_we_re are 0. mem_mask, mem_address and mem_data_in hold their values.
- WAIT:
  - Counter increments each cycle.
  - If mem_valid=1: capture the formatted mem_data_out into rdata and go to DONE.
  - If the counter reaches TIMEOUT_CYC with no valid: set err=1, rdata=0, go to DONE.
  - mem_valid outside WAIT is ignored.
- DONE: done=1 for one cycle, busy deasserts in the same cycle, then go to IDLE. A new ls_req is accepted on the following IDLE cycle.
- Latency from the ls_req cycle to the done cycle:
  - Store: 2 cycles.
  - Load: 3 cycles when memory returns valid one cycle after load.
- Mask generation (o = ls_addr[1:0]):
  - B/BU: 4'b0001<<o
  - H/HU: 4'b0011<<{o[1],0}
  - W: 4'b1111
- Store data:
  - B: {4{wdata[7:0]}}
  - H: {2{wdata[15:0]}}
  - W: wdata
- Load format:
  - Select byte o or halfword o[1].
  - B/H: sign-extend.
  - BU/HU: zero-extend.
  - W: pass through.
- Undefined funct3 (011, 110, 111): treated as W.
- rdata and err hold their values until the next done.

Optional Feature:
- MISALIGN_TRAP_EN
- Defined:
  - H/HU with o[0]=1, or W with o≠0, does not enter REQ; no memory request is issued.
  - Go IDLE→DONE, with done=1, err=1, rdata=0, two cycles after ls_req.
- Undefined: offending low address bits are forced to natural alignment (H clears bit 0, W clears bits 1:0) and the access proceeds normally with err=0.

Test Plan:
- SW addr=0x0000_0010 wdata=0xDEADBEEF → REQ cycle shows mem_request=1, we_re=1, mask=1111, mem_address=0x04, data_in=0xDEADBEEF; done 2 cycles after req, err=0.
- SB addr=0x13 wdata=0x000000A5 → mask=1000, data_in=0xA5A5A5A5, address=0x04.
- Memory word 0x80F0_7F01 at 0x20: LB addr=0x23 → rdata=0xFFFFFF80; LBU addr=0x23 → 0x00000080; LH addr=0x22 → 0xFFFF80F0; LHU addr=0x20 → 0x00007F01; each done 3 cycles after req.
- Load with mem_valid held 0 → err=1, rdata=0, done after TIMEOUT_CYC cycles in WAIT; second ls_req issued during busy produces no extra request.
- Assert rst during WAIT → next cycle busy=0, done=0, all mem_* outputs 0; a subsequent LW completes normally.
- LW addr=0x22: with MISALIGN_TRAP_EN → no mem_request, done+err after 2 cycles; without it → address=0x08, mask=1111, err=0.
